// File: rtl/core_multicycle.sv
// core_multicycle: multi-cycle RV32I-subset core (ADD, SUB, AND, OR, XOR, ADDI, LUI, LW, SW,
// BEQ, BNE, JAL). One instruction at a time through FETCH/DECODE/EXEC/MEM/WB, halting on
// the exit address, an unsupported instruction or a misaligned taken target.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   exit, illegal              halted; halted because of an illegal instruction or target
//   imem_addr/valid/ready/rdata   instruction fetch handshake (rdata valid with ready)
//   dmem_addr/wen/wdata/valid/ready/rdata  data access handshake (wen=1 store, 0 load)

module core_multicycle #(
    parameter int unsigned         WORD_LEN       = 32,
    parameter int unsigned         REGISTER_COUNT = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC       = '0,
    parameter logic [WORD_LEN-1:0] EXIT_ADDR      = WORD_LEN'(8)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                exit,
    output logic                illegal,
    output logic [WORD_LEN-1:0] imem_addr,
    output logic                imem_valid,
    input  logic                imem_ready,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] dmem_addr,
    output logic                dmem_wen,
    output logic [WORD_LEN-1:0] dmem_wdata,
    output logic                dmem_valid,
    input  logic                dmem_ready,
    input  logic [WORD_LEN-1:0] dmem_rdata
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi, OpLui, OpLw, OpSw, OpBeq, OpBne, OpJal, OpIll
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d, dec_op;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] ir_q, ir_d;
    logic [WORD_LEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [WORD_LEN-1:0] imm_q, imm_d, dec_imm;
    logic [WORD_LEN-1:0] alu_q, alu_d;
    logic [WORD_LEN-1:0] target_q, target_d;
    logic                take_q, take_d;
    logic [WORD_LEN-1:0] mdr_q, mdr_d;
    logic                illegal_q, illegal_d;
    logic                imem_valid_q, imem_valid_d;
    logic                dmem_valid_q, dmem_valid_d;
    logic [WORD_LEN-1:0] dmem_addr_q, dmem_addr_d;
    logic                dmem_wen_q, dmem_wen_d;
    logic [WORD_LEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [WORD_LEN-1:0] rf_q [REGISTER_COUNT];

    logic                rf_we;
    logic [WORD_LEN-1:0] rf_wdata;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_idx, rs1_idx, rs2_idx;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign funct3  = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign funct7  = ir_q[31:25];

    // Instruction decode and immediate extraction from the latched IR.
    always_comb begin
        dec_op  = OpIll;
        dec_imm = '0;
        case (opcode)
            7'h33: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'h0:    dec_op = OpAdd;
                        3'h4:    dec_op = OpXor;
                        3'h6:    dec_op = OpOr;
                        3'h7:    dec_op = OpAnd;
                        default: dec_op = OpIll;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'h0) begin
                    dec_op = OpSub;
                end
            end
            7'h13: begin
                if (funct3 == 3'h0) dec_op = OpAddi;
                dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            7'h37: begin
                dec_op  = OpLui;
                dec_imm = {ir_q[31:12], 12'h000};
            end
            7'h03: begin
                if (funct3 == 3'h2) dec_op = OpLw;
                dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
            end
            7'h23: begin
                if (funct3 == 3'h2) dec_op = OpSw;
                dec_imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            end
            7'h63: begin
                if (funct3 == 3'h0) dec_op = OpBeq;
                else if (funct3 == 3'h1) dec_op = OpBne;
                dec_imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            7'h6f: begin
                dec_op  = OpJal;
                dec_imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            default: dec_op = OpIll;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        alu_d        = alu_q;
        target_d     = target_q;
        take_d       = take_q;
        mdr_d        = mdr_q;
        illegal_d    = illegal_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wen_d   = dmem_wen_q;
        dmem_wdata_d = dmem_wdata_q;
        rf_we        = 1'b0;
        rf_wdata     = (op_q == OpLw) ? mdr_q : alu_q;

        unique case (state_q)
            StFetch: begin
                if (pc_q == EXIT_ADDR) begin
                    state_d   = StHalt;
                    illegal_d = 1'b0;
                end else if (imem_valid_q && imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                rs1_d = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
                rs2_d = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
                imm_d = dec_imm;
                op_d  = dec_op;
                if (dec_op == OpIll) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                target_d = pc_q + imm_q;
                take_d   = 1'b0;
                case (op_q)
                    OpAdd:   alu_d = rs1_q + rs2_q;
                    OpSub:   alu_d = rs1_q - rs2_q;
                    OpAnd:   alu_d = rs1_q & rs2_q;
                    OpOr:    alu_d = rs1_q | rs2_q;
                    OpXor:   alu_d = rs1_q ^ rs2_q;
                    OpLui:   alu_d = imm_q;
                    OpBeq:   take_d = (rs1_q == rs2_q);
                    OpBne:   take_d = (rs1_q != rs2_q);
                    OpJal: begin
                        alu_d  = pc_q + WORD_LEN'(4);
                        take_d = 1'b1;
                    end
                    default: alu_d = rs1_q + imm_q;
                endcase
                if (take_d && target_d[1:0] != 2'b00) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else if (op_q == OpLw || op_q == OpSw) begin
                    // Request fields are frozen here and held for the whole MEM wait.
                    dmem_addr_d  = rs1_q + imm_q;
                    dmem_wen_d   = (op_q == OpSw);
                    dmem_wdata_d = rs2_q;
                    state_d      = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_valid_q && dmem_ready) begin
                    if (!dmem_wen_q) mdr_d = dmem_rdata;
                    state_d = StWb;
                end
            end
            StWb: begin
                rf_we = (rd_idx != 5'd0) && (op_q inside {OpAdd, OpSub, OpAnd, OpOr, OpXor,
                                                          OpAddi, OpLui, OpLw, OpJal});
                pc_d    = take_q ? target_q : pc_q + WORD_LEN'(4);
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase

        // Valids are registered: they go high on the edge that enters the requesting state
        // and drop on the handshake edge, since that edge also leaves the state.
        imem_valid_d = (state_d == StFetch) && (pc_d != EXIT_ADDR);
        dmem_valid_d = (state_d == StMem);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            op_q         <= OpIll;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            alu_q        <= '0;
            target_q     <= '0;
            take_q       <= 1'b0;
            mdr_q        <= '0;
            illegal_q    <= 1'b0;
            imem_valid_q <= 1'b0;
            dmem_valid_q <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_wdata_q <= '0;
            for (int unsigned i = 0; i < REGISTER_COUNT; i++) rf_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            alu_q        <= alu_d;
            target_q     <= target_d;
            take_q       <= take_d;
            mdr_q        <= mdr_d;
            illegal_q    <= illegal_d;
            imem_valid_q <= imem_valid_d;
            dmem_valid_q <= dmem_valid_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_wdata_q <= dmem_wdata_d;
            if (rf_we) rf_q[rd_idx] <= rf_wdata;
        end
    end

    assign exit       = (state_q == StHalt);
    assign illegal    = illegal_q;
    assign imem_addr  = pc_q;
    assign imem_valid = imem_valid_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_valid = dmem_valid_q;

endmodule
